// File: rtl/elevator_pkg.sv
// Shared types for the SCAN elevator controller: FSM states, direction
// encoding and the decide rule used at every scheduling point.
package elevator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef struct packed {
    state_t state;
    logic   dir;
  } decision_t;

  // Serve here first, keep sweeping while work lies ahead, otherwise turn
  // around if work lies behind, otherwise rest.
  function automatic decision_t decide(input logic here, input logic above,
                                       input logic below, input logic dir);
    decision_t d;
    d.dir = dir;
    if (here) begin
      d.state = ST_DOOR;
    end else if ((dir == DIR_UP) ? above : below) begin
      d.state = ST_MOVE;
    end else if ((dir == DIR_UP) ? below : above) begin
      d.state = ST_MOVE;
      d.dir   = ~dir;
    end else begin
      d.state = ST_IDLE;
    end
    return d;
  endfunction

endpackage

// File: rtl/elevator_req_latch.sv
// Holds unserved floor requests and reports where the effective requests
// lie relative to a one-hot reference position.
module elevator_req_latch #(
  parameter int NUM_FLOORS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] floor_req,
  input  logic [NUM_FLOORS-1:0] clr,
  input  logic [NUM_FLOORS-1:0] pos,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  here,
  output logic                  above,
  output logic                  below
);

  logic [NUM_FLOORS-1:0] req_eff;
  logic [NUM_FLOORS-1:0] below_mask;
  logic [NUM_FLOORS-1:0] above_mask;

  // Requests seen this cycle count immediately, so a call made as the car
  // reaches a floor is still served there.
  assign req_eff    = pending | floor_req;
  // pos is one-hot, so pos-1 sets exactly the bits of the lower floors.
  assign below_mask = pos - NUM_FLOORS'(1);
  assign above_mask = ~(pos | below_mask);

  assign here  = |(req_eff & pos);
  assign above = |(req_eff & above_mask);
  assign below = |(req_eff & below_mask);

  // Latch new requests and drop the floor currently being served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      pending <= req_eff & ~clr;
    end
  end

endmodule

// File: rtl/elevator_scan_controller.sv
// N-floor elevator car controller: SCAN scheduling over latched requests,
// timed travel between floors and a retriggerable door dwell.
module elevator_scan_controller
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = 5,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] floor_req,
  output logic [NUM_FLOORS-1:0] floor_pos,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  moving_up,
  output logic                  moving_down,
  output logic                  door_open,
  output logic                  arrived
);

  if (NUM_FLOORS < 2) begin : g_bad_floors
    $error("NUM_FLOORS must be at least 2");
  end
  if (TRAVEL_CYCLES < 1) begin : g_bad_travel
    $error("TRAVEL_CYCLES must be at least 1");
  end
  if (DOOR_CYCLES < 1) begin : g_bad_door
    $error("DOOR_CYCLES must be at least 1");
  end

  localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);
  // Timers count down to zero and act on the edge after reaching it.
  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);
  localparam logic [NUM_FLOORS-1:0] HOME = NUM_FLOORS'(1);

  state_t          state, state_nxt;
  logic            dir, dir_nxt;
  logic [TW-1:0]   travel_tmr, travel_tmr_nxt;
  logic [TW-1:0]   door_tmr, door_tmr_nxt;
  logic [NUM_FLOORS-1:0] step_pos, eval_pos, clr;
  logic            arrive, req_here, here, above, below, take;
  decision_t       dec;

  elevator_req_latch #(.NUM_FLOORS(NUM_FLOORS)) u_req_latch (
    .clk       (clk),
    .rst       (rst),
    .floor_req (floor_req),
    .clr       (clr),
    .pos       (eval_pos),
    .pending   (pending),
    .here      (here),
    .above     (above),
    .below     (below)
  );

  // Neighbouring floor in the current direction, pinned at the end floors.
  always_comb begin
    // NOTE: default first so no path through always_comb infers a latch.
    step_pos = floor_pos;
    if (dir == DIR_UP && !floor_pos[NUM_FLOORS-1]) begin
      step_pos = floor_pos << 1;
    end else if (dir == DIR_DOWN && !floor_pos[0]) begin
      step_pos = floor_pos >> 1;
    end
  end

  // Decisions on arrival are taken against the floor being entered.
  assign arrive   = (state == ST_MOVE) && (travel_tmr == '0);
  assign eval_pos = arrive ? step_pos : floor_pos;
  assign req_here = |(floor_req & floor_pos);
  assign dec      = decide(here, above, below, dir);
  assign clr      = (state == ST_DOOR || state_nxt == ST_DOOR) ? eval_pos : '0;

  // Next-state, direction and timer updates.
  always_comb begin
    state_nxt      = state;
    dir_nxt        = dir;
    travel_tmr_nxt = travel_tmr;
    door_tmr_nxt   = door_tmr;
    take           = 1'b0;
    case (state)
      ST_IDLE: take = 1'b1;
      ST_MOVE: begin
        if (travel_tmr == '0) take = 1'b1;
        else                  travel_tmr_nxt = travel_tmr - 1'b1;
      end
      ST_DOOR: begin
        // A fresh call at the open door restarts the dwell instead of latching.
        if (req_here)              door_tmr_nxt = DOOR_LOAD;
        else if (door_tmr == '0)   take = 1'b1;
        else                       door_tmr_nxt = door_tmr - 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (take) begin
      state_nxt = dec.state;
      dir_nxt   = dec.dir;
      if (dec.state == ST_MOVE) travel_tmr_nxt = TRAVEL_LOAD;
      if (dec.state == ST_DOOR) door_tmr_nxt   = DOOR_LOAD;
    end
  end

  // State, position, timers and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      dir         <= DIR_UP;
      travel_tmr  <= '0;
      door_tmr    <= '0;
      floor_pos   <= HOME;
      moving_up   <= 1'b0;
      moving_down <= 1'b0;
      door_open   <= 1'b0;
      arrived     <= 1'b0;
    end else begin
      state       <= state_nxt;
      dir         <= dir_nxt;
      travel_tmr  <= travel_tmr_nxt;
      door_tmr    <= door_tmr_nxt;
      floor_pos   <= eval_pos;
      moving_up   <= (state_nxt == ST_MOVE) && (dir_nxt == DIR_UP);
      moving_down <= (state_nxt == ST_MOVE) && (dir_nxt == DIR_DOWN);
      door_open   <= (state_nxt == ST_DOOR);
      arrived     <= (state_nxt == ST_DOOR) && (state != ST_DOOR);
    end
  end

endmodule

// File: tb/tb_elevator_scan_controller.sv
// Self-checking bench for elevator_scan_controller: directed scenarios and
// random request traffic against a floor-number-level reference model.
`timescale 1ns/1ps
module tb_elevator_scan_controller;

  localparam int N  = 5;
  localparam int T  = 4;
  localparam int D  = 3;
  localparam int VW = 2 * N + 4;
  localparam int M_IDLE = 0, M_MOVE = 1, M_DOOR = 2;

  logic         clk, rst;
  logic [N-1:0] floor_req, floor_pos, pending;
  logic         moving_up, moving_down, door_open, arrived;

  int checks = 0;
  int errors = 0;

  // Reference model: integer floor number, activity, elapsed edges in it.
  int           m_floor, m_mode, m_cnt;
  bit           m_up, m_arr;
  logic [N-1:0] m_pend;

  elevator_scan_controller #(.NUM_FLOORS(N), .TRAVEL_CYCLES(T), .DOOR_CYCLES(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .floor_req   (floor_req),
    .floor_pos   (floor_pos),
    .pending     (pending),
    .moving_up   (moving_up),
    .moving_down (moving_down),
    .door_open   (door_open),
    .arrived     (arrived)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [VW-1:0] dut_vec();
    return {floor_pos, pending, moving_up, moving_down, door_open, arrived};
  endfunction

  function automatic logic [VW-1:0] m_vec();
    logic [N-1:0] p;
    p = '0;
    p[m_floor-1] = 1'b1;
    return {p, m_pend, (m_mode == M_MOVE) && m_up, (m_mode == M_MOVE) && !m_up,
            m_mode == M_DOOR, m_arr};
  endfunction

  function automatic int floor_of(input logic [N-1:0] p);
    for (int i = 0; i < N; i++) if (p[i]) return i + 1;
    return 0;
  endfunction

  task automatic m_reset();
    m_floor = 1; m_mode = M_IDLE; m_cnt = 0; m_up = 1'b1; m_arr = 1'b0; m_pend = '0;
  endtask

  task automatic m_decide(input logic [N-1:0] req);
    bit ahead, behind;
    ahead = 0; behind = 0;
    for (int f = 1; f <= N; f++) begin
      if (req[f-1] && (m_up ? f > m_floor : f < m_floor)) ahead = 1;
      if (req[f-1] && (m_up ? f < m_floor : f > m_floor)) behind = 1;
    end
    m_cnt = 0;
    if (req[m_floor-1])  m_mode = M_DOOR;
    else if (ahead)      m_mode = M_MOVE;
    else if (behind)     begin m_up = !m_up; m_mode = M_MOVE; end
    else                 m_mode = M_IDLE;
  endtask

  task automatic m_step(input logic [N-1:0] r);
    logic [N-1:0] req, clr;
    int old_mode;
    req = m_pend | r;
    old_mode = m_mode;
    case (m_mode)
      M_IDLE: m_decide(req);
      M_MOVE: begin
        m_cnt++;
        if (m_cnt == T) begin
          m_floor = m_up ? m_floor + 1 : m_floor - 1;
          m_decide(req);
        end
      end
      default: begin
        if (r[m_floor-1]) m_cnt = 0;
        else begin
          m_cnt++;
          if (m_cnt == D) m_decide(req);
        end
      end
    endcase
    clr = '0;
    if (old_mode == M_DOOR || m_mode == M_DOOR) clr[m_floor-1] = 1'b1;
    m_pend = req & ~clr;
    m_arr  = (m_mode == M_DOOR) && (old_mode != M_DOOR);
  endtask

  // Drive one cycle of requests, advance the model on the edge, return its view.
  task automatic tick(input logic [N-1:0] r, output logic [VW-1:0] e);
    floor_req = r;
    @(posedge clk);
    m_step(r);
    #1;
    e = m_vec();
  endtask

  task automatic test_reset();
    logic [VW-1:0] e;
    rst = 1'b1; floor_req = '0; m_reset();
    repeat (2) @(posedge clk);
    #1;
    e = {N'(1), {N{1'b0}}, 4'b0000};
    checks++;
    if (dut_vec() !== e) begin
      errors++; $display("FAIL reset got %b exp %b", dut_vec(), e);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_request();
    logic [VW-1:0] e;
    int f2_at, f3_at, n_arr, n_door;
    bit done;
    f2_at = -1; f3_at = -1; n_arr = 0; n_door = 0; done = 0;
    tick(5'b00100, e);
    checks++;
    if (pending !== 5'b00100 || moving_up !== 1'b1 || moving_down !== 1'b0) begin
      errors++; $display("FAIL single_start got pend %b up %b exp pend 00100 up 1", pending, moving_up);
    end
    for (int i = 1; i < 60 && !done; i++) begin
      tick('0, e);
      checks++;
      if (dut_vec() !== e) begin
        errors++; $display("FAIL single cyc %0d got %b exp %b", i, dut_vec(), e);
      end
      if (floor_pos == 5'b00010 && f2_at < 0) f2_at = i;
      if (floor_pos == 5'b00100 && f3_at < 0) f3_at = i;
      n_arr  += int'(arrived);
      n_door += int'(door_open);
      done = (m_mode == M_IDLE);
    end
    checks++;
    if (f2_at != T || f3_at != 2 * T || n_arr != 1 || n_door != D || !done) begin
      errors++;
      $display("FAIL single_timing got f2 %0d f3 %0d arr %0d door %0d idle %0d exp %0d %0d 1 %0d 1",
               f2_at, f3_at, n_arr, n_door, done, T, 2 * T, D);
    end
    checks++;
    if (pending !== '0 || door_open !== 1'b0 || moving_up !== 1'b0) begin
      errors++; $display("FAIL single_end got pend %b door %b up %b exp 0 0 0", pending, door_open, moving_up);
    end
  endtask

  task automatic test_scan_reverse();
    logic [VW-1:0] e;
    int seq;
    bit done, door5_done, early_down;
    seq = 0; done = 0; door5_done = 0; early_down = 0;
    tick(5'b10000, e);
    tick(5'b10001, e);
    for (int i = 0; i < 120 && !done; i++) begin
      tick('0, e);
      checks++;
      if (dut_vec() !== e) begin
        errors++; $display("FAIL scan cyc %0d got %b exp %b", i, dut_vec(), e);
      end
      if (arrived) seq = seq * 10 + floor_of(floor_pos);
      if (seq == 5 && !door_open) door5_done = 1;
      if (moving_down && !door5_done) early_down = 1;
      done = (m_mode == M_IDLE);
    end
    checks++;
    if (seq != 51 || early_down || !done) begin
      errors++; $display("FAIL scan_order got seq %0d early_down %0d exp seq 51 early_down 0", seq, early_down);
    end
  endtask

  task automatic test_multi_stop();
    logic [VW-1:0] e;
    int seq, n_arr;
    bit done;
    seq = 0; n_arr = 0; done = 0;
    tick(5'b11010, e);
    for (int i = 0; i < 120 && !done; i++) begin
      tick('0, e);
      checks++;
      if (dut_vec() !== e) begin
        errors++; $display("FAIL multi cyc %0d got %b exp %b", i, dut_vec(), e);
      end
      if (arrived) begin seq = seq * 10 + floor_of(floor_pos); n_arr++; end
      done = (m_mode == M_IDLE);
    end
    checks++;
    if (seq != 245 || n_arr != 3) begin
      errors++; $display("FAIL multi_order got seq %0d arrivals %0d exp seq 245 arrivals 3", seq, n_arr);
    end
  endtask

  task automatic test_top_boundary();
    logic [VW-1:0] e;
    int seq;
    bit done, bad_pos;
    seq = 0; done = 0; bad_pos = 0;
    tick(5'b10100, e);
    checks++;
    if (door_open !== 1'b1 || floor_pos !== 5'b10000 || pending !== 5'b00100) begin
      errors++; $display("FAIL top_door got door %b pos %b pend %b exp 1 10000 00100", door_open, floor_pos, pending);
    end
    for (int i = 0; i < 80 && !done; i++) begin
      tick('0, e);
      checks++;
      if (dut_vec() !== e) begin
        errors++; $display("FAIL top cyc %0d got %b exp %b", i, dut_vec(), e);
      end
      if (!$onehot(floor_pos)) bad_pos = 1;
      if (arrived) seq = seq * 10 + floor_of(floor_pos);
      done = (m_mode == M_IDLE);
    end
    checks++;
    if (seq != 3 || bad_pos || floor_pos !== 5'b00100) begin
      errors++; $display("FAIL top_end got seq %0d bad_pos %0d pos %b exp 3 0 00100", seq, bad_pos, floor_pos);
    end
  endtask

  task automatic test_door_retrigger();
    logic [VW-1:0] e;
    int n_door;
    bit done;
    done = 0; n_door = 0;
    tick(5'b00010, e);
    for (int i = 0; i < 80 && !done; i++) begin
      tick('0, e);
      checks++;
      if (dut_vec() !== e) begin
        errors++; $display("FAIL retrig_go cyc %0d got %b exp %b", i, dut_vec(), e);
      end
      done = (m_mode == M_IDLE);
    end
    tick(5'b00010, e);
    checks++;
    if (door_open !== 1'b1 || arrived !== 1'b1 || floor_pos !== 5'b00010 ||
        moving_up !== 1'b0 || moving_down !== 1'b0) begin
      errors++; $display("FAIL idle_here got door %b arr %b pos %b exp 1 1 00010", door_open, arrived, floor_pos);
    end
    tick(5'b00010, e);
    checks++;
    if (door_open !== 1'b1 || arrived !== 1'b0 || pending !== '0) begin
      errors++; $display("FAIL retrig_edge got door %b arr %b pend %b exp 1 0 00000", door_open, arrived, pending);
    end
    for (int i = 0; i < 4; i++) begin
      tick('0, e);
      checks++;
      if (dut_vec() !== e) begin
        errors++; $display("FAIL retrig cyc %0d got %b exp %b", i, dut_vec(), e);
      end
      n_door += int'(door_open);
    end
    checks++;
    if (n_door != D - 1) begin
      errors++; $display("FAIL retrig_len got %0d exp %0d", n_door, D - 1);
    end
  endtask

  task automatic test_reset_mid_move();
    logic [VW-1:0] e;
    tick(5'b10000, e);
    repeat (5) tick('0, e);
    #2 rst = 1'b1;
    #1;
    e = {N'(1), {N{1'b0}}, 4'b0000};
    checks++;
    if (dut_vec() !== e) begin
      errors++; $display("FAIL reset_mid got %b exp %b", dut_vec(), e);
    end
    m_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_random();
    logic [VW-1:0] e;
    logic [N-1:0]  r;
    bit done;
    done = 0;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      tick(r, e);
      checks++;
      if (dut_vec() !== e) begin
        errors++; $display("FAIL random cyc %0d req %b got %b exp %b", i, r, dut_vec(), e);
      end
    end
    for (int i = 0; i < 200 && !done; i++) begin
      tick('0, e);
      checks++;
      if (dut_vec() !== e) begin
        errors++; $display("FAIL drain cyc %0d got %b exp %b", i, dut_vec(), e);
      end
      done = (m_mode == M_IDLE) && (m_pend == '0);
    end
    checks++;
    if (!done || pending !== '0) begin
      errors++; $display("FAIL drain_end got pend %b exp 00000", pending);
    end
  endtask

  initial begin
    test_reset();
    test_single_request();
    test_scan_reverse();
    test_multi_stop();
    test_top_boundary();
    test_door_retrigger();
    test_reset_mid_move();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
